// File: rtl/mu_dac_ctl_if.sv
// Wishbone classic slave bus for the measure-unit threshold DAC controller.
interface mu_dac_ctl_if;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_adr_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/mu_dac_ctl.sv
// N-channel comparator-threshold DAC controller: per-channel codes, broadcast,
// and one shared SPI engine serving pending channels in round-robin order.
module mu_dac_ctl #(
  parameter int N_CH        = 2,
  parameter int CODE_W      = 16,
  parameter int CLK_DIV     = 3,
  parameter int WAIT_CYCLES = 3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  mu_dac_ctl_if.slave     wb,
  output logic [N_CH-1:0] dac_sync_o,
  output logic            dac_sclk_o,
  output logic            dac_sdi_o,
  output logic            busy_o
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int GAP_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WAIT_CYCLES - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wr,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    m = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) m[8*b +: 8] = wr[8*b +: 8];
    return m;
  endfunction

  logic              ack_q;
  logic [31:0]       dat_q;
  logic [CODE_W-1:0] code_q [N_CH];
  logic [CODE_W-1:0] bcast_q;
  logic [7:0]        prefix_q;
  logic [15:0]       frames_q;
  logic [N_CH-1:0]   pend_q, pend_set, pend_clr;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d, pick;
  logic              pick_vld, frame_done, busy;

  logic              wb_req, wb_wr, code_hit;
  logic [3:0]        word;
  logic [2:0]        code_off;
  logic [CH_W-1:0]   code_idx;
  logic [31:0]       cur_val, wr_val, rd_data;
  logic              unused_bits;

  assign wb_req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wb_wr    = wb_req & wb.wb_we_i;
  assign word     = wb.wb_adr_i[5:2];
  assign code_off = word[2:0];
  assign code_hit = word[3] && (int'(code_off) < N_CH);
  assign code_idx = CH_W'(code_off);
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign unused_bits = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0], wr_val[31:CODE_W]};

  // Current register value of the addressed word; also the base for byte merging
  always_comb begin
    cur_val = '0;
    case (word)
      4'd1:    cur_val[CODE_W-1:0] = bcast_q;
      4'd2:    cur_val[7:0]        = prefix_q;
      default: if (code_hit) cur_val[CODE_W-1:0] = code_q[code_idx];
    endcase
  end

  assign wr_val = merge_bytes(cur_val, wb.wb_dat_i, wb.wb_sel_i);

  always_comb begin
    rd_data = cur_val;
    case (word)
      4'd0: begin
        rd_data[16]       = busy;
        rd_data[N_CH-1:0] = pend_q;
      end
      4'd3:    rd_data[15:0] = frames_q;
      default: ;
    endcase
  end

  always_comb begin
    pend_set = '0;
    if (wb_wr) begin
      if (word == 4'd0) begin
        if (wb.wb_sel_i[0] && wb.wb_dat_i[0]) pend_set = '1;
      end else if (word == 4'd1) begin
        pend_set = '1;
      end else if (code_hit) begin
        pend_set[code_idx] = 1'b1;
      end
    end
  end

  // Bus register stage: ack, read data and register writes share the ack edge
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      bcast_q  <= '0;
      prefix_q <= '0;
      for (int i = 0; i < N_CH; i++) code_q[i] <= '0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) dat_q <= rd_data;
      if (wb_wr) begin
        case (word)
          4'd1: begin
            bcast_q <= wr_val[CODE_W-1:0];
            for (int i = 0; i < N_CH; i++) code_q[i] <= wr_val[CODE_W-1:0];
          end
          4'd2:    prefix_q <= wr_val[7:0];
          default: if (code_hit) code_q[code_idx] <= wr_val[CODE_W-1:0];
        endcase
      end
    end
  end

  // First pending channel at or after rr_q, wrapping; lowest offset wins
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (pend_q[CH_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    shreg_d    = shreg_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    pend_clr   = '0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d        = SHIFT;
          ch_d           = pick;
          rr_d           = (int'(pick) == N_CH - 1) ? '0 : pick + 1'b1;
          pend_clr[pick] = 1'b1;
          shreg_d        = {prefix_q, 16'(code_q[pick])};
          div_d          = '0;
          bit_d          = '0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state stage; a set on the clear cycle keeps the channel pending
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      ch_q     <= '0;
      rr_q     <= '0;
      pend_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      pend_q  <= (pend_q & ~pend_clr) | pend_set;
      if (frame_done) frames_q <= frames_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    shreg_q <= shreg_d;
  end

  assign busy   = (state_q != IDLE) | (|pend_q);
  assign busy_o = busy;

  always_comb begin
    dac_sync_o = '1;
    dac_sclk_o = 1'b1;
    dac_sdi_o  = 1'b0;
    if (state_q == SHIFT) begin
      dac_sync_o[ch_q] = 1'b0;
      dac_sclk_o       = (div_q < DIV_HALF);
      dac_sdi_o        = shreg_q[23];
    end
  end
endmodule

// File: tb/tb_mu_dac_ctl.sv
// Bench for mu_dac_ctl: directed scenarios plus random bus traffic against a
// cycle-level behavioural model and an SPI receiver decoding the DAC frames.
module tb_mu_dac_ctl;
  localparam int N_CH   = 4;
  localparam int CODE_W = 16;
  localparam int CD     = 3;
  localparam int WC     = 3;
  localparam int FLEN   = 48 * CD + WC;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic [N_CH-1:0] dac_sync_o;
  logic            dac_sclk_o, dac_sdi_o, busy_o;

  mu_dac_ctl_if bus ();

  mu_dac_ctl #(.N_CH(N_CH), .CODE_W(CODE_W), .CLK_DIV(CD), .WAIT_CYCLES(WC)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wb         (bus),
    .dac_sync_o (dac_sync_o),
    .dac_sclk_o (dac_sclk_o),
    .dac_sdi_o  (dac_sdi_o),
    .busy_o     (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [CODE_W-1:0] m_code [N_CH];
  logic [CODE_W-1:0] m_bcast;
  logic [7:0]        m_prefix;
  logic [15:0]       m_frames;
  logic [N_CH-1:0]   m_pend, mq_clr, mq_set;
  int                m_rr, m_cnt, m_ch, mq_word;
  logic [23:0]       m_frame;
  logic              m_ack, mq_req, mq_found;
  logic [31:0]       m_rd, mq_nv;
  logic [26:0]       exp_q [$];
  logic [26:0]       rx_log [$];

  function automatic logic [31:0] mmerge(input logic [31:0] cur, input logic [31:0] wr,
                                         input logic [3:0] sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wr[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    logic [31:0] r;
    r = 32'd0;
    if (w == 0)      r = {15'd0, (m_cnt > 0 || m_pend != 0), 12'd0, m_pend};
    else if (w == 1) r = {16'd0, m_bcast};
    else if (w == 2) r = {24'd0, m_prefix};
    else if (w == 3) r = {16'd0, m_frames};
    else if (w >= 8 && w < 8 + N_CH) r = {16'd0, m_code[w-8]};
    return r;
  endfunction

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < N_CH; i++) m_code[i] = '0;
      m_bcast = '0; m_prefix = '0; m_frames = '0; m_pend = '0;
      m_rr = 0; m_cnt = 0; m_ch = 0; m_frame = '0; m_ack = 1'b0; m_rd = '0;
      exp_q.delete();
    end else begin
      mq_req  = bus.wb_cyc_i & bus.wb_stb_i & ~m_ack;
      mq_word = int'(bus.wb_adr_i[5:2]);
      if (mq_req) m_rd = model_read(mq_word);
      mq_clr = '0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_frames++;
      end else if (m_pend != 0) begin
        mq_found = 1'b0;
        for (int k = 0; k < N_CH; k++)
          if (!mq_found && m_pend[(m_rr + k) % N_CH]) begin
            mq_found = 1'b1;
            m_ch = (m_rr + k) % N_CH;
          end
        m_frame = {m_prefix, m_code[m_ch]};
        exp_q.push_back({3'(m_ch), m_frame});
        mq_clr[m_ch] = 1'b1;
        m_rr  = (m_ch + 1) % N_CH;
        m_cnt = FLEN;
      end
      mq_set = '0;
      if (mq_req && bus.wb_we_i) begin
        mq_nv = mmerge(model_read(mq_word), bus.wb_dat_i, bus.wb_sel_i);
        if (mq_word == 0) begin
          if (bus.wb_sel_i[0] && bus.wb_dat_i[0]) mq_set = '1;
        end else if (mq_word == 1) begin
          m_bcast = mq_nv[15:0];
          for (int i = 0; i < N_CH; i++) m_code[i] = mq_nv[15:0];
          mq_set = '1;
        end else if (mq_word == 2) begin
          m_prefix = mq_nv[7:0];
        end else if (mq_word >= 8 && mq_word < 8 + N_CH) begin
          m_code[mq_word-8] = mq_nv[15:0];
          mq_set[mq_word-8] = 1'b1;
        end
      end
      m_pend = (m_pend & ~mq_clr) | mq_set;
      m_ack  = mq_req;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic            run_cmp = 1'b0;
  logic [N_CH-1:0] e_sync;
  logic            e_sclk, e_sdi;
  int              e_t;

  always @(negedge wb_clk_i) begin
    if (run_cmp) begin
      e_sync = '1; e_sclk = 1'b1; e_sdi = 1'b0;
      if (m_cnt > WC) begin
        e_t = FLEN - m_cnt;
        e_sync[m_ch] = 1'b0;
        e_sclk = ((e_t % (2 * CD)) < CD);
        e_sdi  = m_frame[23 - e_t / (2 * CD)];
      end
      check("cyc_sync", 32'(dac_sync_o), 32'(e_sync));
      check("cyc_sclk", 32'(dac_sclk_o), 32'(e_sclk));
      check("cyc_sdi", 32'(dac_sdi_o), 32'(e_sdi));
      check("cyc_busy", 32'(busy_o), 32'(m_cnt > 0 || m_pend != 0));
      check("cyc_ack", 32'(bus.wb_ack_o), 32'(m_ack));
      check("cyc_dat_o", bus.wb_dat_o, m_rd);
    end
  end

  // ---------------- SPI receiver (samples on sclk fall) ----------------
  logic        rx_active = 1'b0, rx_prev_sclk = 1'b1;
  int          rx_low, rx_bits, rx_ch, rx_nlow;
  logic [23:0] rx_word;
  logic [26:0] rx_exp;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_active = 1'b0;
      rx_prev_sclk = 1'b1;
    end else begin
      if (dac_sync_o != '1) begin
        if (!rx_active) begin
          rx_active = 1'b1; rx_low = 0; rx_bits = 0; rx_word = '0; rx_nlow = 0; rx_ch = 0;
          for (int i = 0; i < N_CH; i++) if (!dac_sync_o[i]) begin rx_ch = i; rx_nlow++; end
          check("sync_onehot", 32'(rx_nlow), 32'd1);
        end
        rx_low++;
        if (rx_prev_sclk && !dac_sclk_o) begin
          rx_word = {rx_word[22:0], dac_sdi_o};
          rx_bits++;
        end
      end else if (rx_active) begin
        rx_active = 1'b0;
        check("frame_sync_low_cycles", 32'(rx_low), 32'(48 * CD));
        check("frame_bits", 32'(rx_bits), 32'd24);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          rx_exp = exp_q.pop_front();
          check("frame_content", 32'({3'(rx_ch), rx_word}), 32'(rx_exp));
        end
        rx_log.push_back({3'(rx_ch), rx_word});
      end
      rx_prev_sclk = dac_sclk_o;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_xfer(input logic we, input int w, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd);
    @(negedge wb_clk_i);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = {26'd0, 4'(w), 2'b00}; bus.wb_dat_i = d; bus.wb_sel_i = sel;
    @(posedge wb_clk_i);
    #1;
    rd = bus.wb_dat_o;
    @(negedge wb_clk_i);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wr(input int w, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, w, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string name, input int w, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(1'b0, w, 32'd0, 4'hF, r);
    check(name, r, exp);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    repeat (2) @(negedge wb_clk_i);
    while (busy_o && n < maxc) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("wait_idle_timeout", 32'(busy_o), 32'd0);
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic log_chk(input string name, input int idx, input logic [26:0] exp);
    logic [26:0] v;
    v = (rx_log.size() > idx) ? rx_log[idx] : '1;
    check($sformatf("%s_%0d", name, idx), 32'(v), 32'(exp));
  endtask

  int wsel [11] = '{0, 1, 2, 3, 5, 8, 9, 10, 11, 12, 15};

  initial begin
    logic [31:0] r;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    repeat (3) @(negedge wb_clk_i);
    run_cmp = 1'b1;
    wb_rst_i = 1'b0;

    // reset state
    check("rst_sync", 32'(dac_sync_o), 32'hF);
    check("rst_sclk", 32'(dac_sclk_o), 32'd1);
    rd_chk("rst_ctl", 0, 32'd0);
    rd_chk("rst_frames", 3, 32'd0);
    rd_chk("rst_code0", 8, 32'd0);

    // broadcast: channels 0..3 in order
    wr(2, 32'h30);
    rx_log.delete();
    wr(1, 32'h0000ABCD);
    repeat (20) @(negedge wb_clk_i);
    rd_chk("bcast_ctl_mid", 0, 32'h0001000E);
    wait_idle(3000);
    check("bcast_nframes", 32'(rx_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) log_chk("bcast_frame", i, {3'(i), 24'h30ABCD});
    rd_chk("bcast_frames", 3, 32'd4);
    rd_chk("bcast_read", 1, 32'h0000ABCD);
    rd_chk("bcast_code3", 11, 32'h0000ABCD);

    // single write
    rx_log.delete();
    wr(9, 32'h1234);
    wait_idle(1000);
    check("single_nframes", 32'(rx_log.size()), 32'd1);
    log_chk("single_frame", 0, {3'd1, 24'h301234});
    rd_chk("single_frames", 3, 32'd5);

    // rewrite in flight
    wr(2, 32'h0);
    rx_log.delete();
    wr(8, 32'h1);
    repeat (30) @(negedge wb_clk_i);
    wr(8, 32'h2);
    wait_idle(2000);
    log_chk("rewrite_frame", 0, {3'd0, 24'h000001});
    log_chk("rewrite_frame", 1, {3'd0, 24'h000002});
    rd_chk("rewrite_frames", 3, 32'd7);

    // round robin
    rx_log.delete();
    wr(10, 32'h2222);
    repeat (10) @(negedge wb_clk_i);
    wr(11, 32'h3333);
    wr(8, 32'h0C0C);
    wait_idle(3000);
    log_chk("rr_frame", 0, {3'd2, 24'h002222});
    log_chk("rr_frame", 1, {3'd3, 24'h003333});
    log_chk("rr_frame", 2, {3'd0, 24'h000C0C});

    // byte select and unmapped word
    wr(2, 32'h30);
    rx_log.delete();
    wr(9, 32'h5555);
    wr(10, 32'h1111);
    bus_xfer(1'b1, 10, 32'h0000FF00, 4'b0010, r);
    rd_chk("bsel_ctl_pending2", 0, 32'h00010004);
    rd_chk("bsel_code2", 10, 32'h0000FF11);
    wr(5, 32'hDEAD);
    rd_chk("unmapped_word5", 5, 32'd0);
    wait_idle(2000);
    log_chk("bsel_frame", 0, {3'd1, 24'h305555});
    log_chk("bsel_frame", 1, {3'd2, 24'h30FF11});
    rd_chk("bsel_frames", 3, 32'd12);

    // random traffic against the model
    for (int it = 0; it < 150; it++) begin
      bus_xfer(1'($urandom_range(0, 1)), wsel[$urandom_range(0, 10)], $urandom,
               4'($urandom_range(0, 15)), r);
      repeat ($urandom_range(0, 80)) @(negedge wb_clk_i);
    end
    wait_idle(3000);

    // reset in the middle of a frame
    rx_log.delete();
    wr(8, 32'h0077);
    repeat (40) @(negedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("midrst_sync", 32'(dac_sync_o), 32'hF);
    check("midrst_sclk", 32'(dac_sclk_o), 32'd1);
    check("midrst_sdi", 32'(dac_sdi_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    rd_chk("midrst_ctl", 0, 32'd0);
    rd_chk("midrst_frames", 3, 32'd0);
    rd_chk("midrst_code0", 8, 32'd0);
    repeat (200) @(negedge wb_clk_i);
    check("midrst_no_frame", 32'(rx_log.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
